// File: rtl/wbsram16.sv
// Wishbone classic slave to 16-bit async SRAM; each word becomes up to two halfword accesses, low half first.
// Ack/err are registered pulses, ack (WAIT_CYCLES+2)*H+1 cycles after acceptance; no stall, dropping cyc aborts.
module wbsram16 #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int SW          = 4,
    parameter int MUXWIDTH    = 3,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [AW-1:0]      i_wb_addr,
    input  logic [DW-1:0]      i_wb_data,
    input  logic [SW-1:0]      i_wb_sel,
    output logic               o_wb_ack,
    output logic [DW-1:0]      o_wb_data,
    output logic               o_wb_err,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [15:0]        o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [15:0]        i_sram_dq_in,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [DW-1:0]        wdat_q, wdat_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [SRAM_AW-2:0]   waddr_q, waddr_d;
    logic                 half_q, half_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DW-1:0]        rbuf_q, rbuf_d;

    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [15:0]          dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                 lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic                 ack_q, ack_d, err_q, err_d;
    logic [DW-1:0]        wb_data_q, wb_data_d;

    logic                 start_vld, start_h;
    logic [1:0]           half_sel;
    logic [15:0]          lane_mask;
    logic                 range_bad;
    logic                 unused_addr;

    assign range_bad   = |i_wb_addr[AW-MUXWIDTH-1:SRAM_AW-1];
    assign unused_addr = &{1'b0, i_wb_addr[AW-1:AW-MUXWIDTH]};
    assign half_sel    = half_q ? sel_q[3:2] : sel_q[1:0];
    assign lane_mask   = {{8{half_sel[1]}}, {8{half_sel[0]}}};

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        waddr_d   = waddr_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        rbuf_d    = rbuf_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wb_data_d = wb_data_q;
        start_vld = 1'b0;
        start_h   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ack/err still high here means the master's stb is stale
                if (i_wb_cyc && i_wb_stb && !ack_q && !err_q) begin
                    we_d    = i_wb_we;
                    wdat_d  = i_wb_data;
                    sel_d   = i_wb_sel;
                    waddr_d = i_wb_addr[SRAM_AW-2:0];
                    rbuf_d  = '0;
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else if (i_wb_sel == '0) begin
                        ack_d     = 1'b1;
                        wb_data_d = '0;
                    end else begin
                        start_vld = 1'b1;
                        start_h   = (i_wb_sel[1:0] == 2'b00);
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                if (we_q) we_n_d = 1'b0;
                else      oe_n_d = 1'b0;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!we_q) begin
                        if (half_q) rbuf_d[31:16] = i_sram_dq_in & lane_mask;
                        else        rbuf_d[15:0]  = i_sram_dq_in & lane_mask;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (!half_q && sel_q[3:2] != 2'b00) begin
                    start_vld = 1'b1;
                    start_h   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    ce_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (!we_q) wb_data_d = rbuf_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_vld) begin
            state_d = S_SETUP;
            half_d  = start_h;
            addr_d  = {waddr_d, start_h};
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            lb_n_d  = start_h ? !sel_d[2] : !sel_d[0];
            ub_n_d  = start_h ? !sel_d[3] : !sel_d[1];
            dq_oe_d = we_d;
            if (we_d) dq_out_d = start_h ? wdat_d[31:16] : wdat_d[15:0];
        end

        // Master dropped cyc: release the SRAM at once, whatever half was in flight
        if (state_q != S_IDLE && !i_wb_cyc) begin
            state_d   = S_IDLE;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            we_n_d    = 1'b1;
            lb_n_d    = 1'b1;
            ub_n_d    = 1'b1;
            dq_oe_d   = 1'b0;
            ack_d     = 1'b0;
            err_d     = 1'b0;
            wb_data_d = wb_data_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            sel_q     <= '0;
            waddr_q   <= '0;
            half_q    <= 1'b0;
            cnt_q     <= '0;
            rbuf_q    <= '0;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            waddr_q   <= waddr_d;
            half_q    <= half_d;
            cnt_q     <= cnt_d;
            rbuf_q    <= rbuf_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign o_wb_ack      = ack_q;
    assign o_wb_err      = err_q;
    assign o_wb_data     = wb_data_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_dq_out = dq_out_q;
    assign o_sram_dq_oe  = dq_oe_q;
    assign o_sram_ce_n   = ce_n_q;
    assign o_sram_oe_n   = oe_n_q;
    assign o_sram_we_n   = we_n_q;
    assign o_sram_lb_n   = lb_n_q;
    assign o_sram_ub_n   = ub_n_q;

endmodule

// File: tb/tb_wbsram16.sv
// Bench for wbsram16: directed Wishbone transfers against a behavioural SRAM, responses checked by a scoreboard monitor.
module tb_wbsram16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        ack, err;
    logic [31:0] rdata;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wbsram16 dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_ack(ack), .o_wb_data(rdata), .o_wb_err(err),
        .o_sram_addr(sram_addr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe),
        .i_sram_dq_in(dq_in),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural asynchronous SRAM with byte lanes
    logic [15:0] mem [int];
    int          wstb, rstb, ce_lo;
    logic [17:0] last_addr;
    logic [1:0]  last_lanes;
    logic [15:0] last_dq;
    logic        last_dqoe;

    function automatic logic [15:0] rd(input int a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            logic [15:0] w;
            w = rd(int'(sram_addr));
            if (!lb_n) w[7:0]  = dq_out[7:0];
            if (!ub_n) w[15:8] = dq_out[15:8];
            mem[int'(sram_addr)] = w;
        end
    end

    always @(negedge clk) begin
        dq_in = (!ce_n && !oe_n) ? rd(int'(sram_addr)) : 16'h0000;
        if (!ce_n) ce_lo++;
        if (!ce_n && !oe_n) rstb++;
        if (!ce_n && !we_n) begin
            wstb++;
            last_addr  = sram_addr;
            last_lanes = {ub_n, lb_n};
            last_dq    = dq_out;
            last_dqoe  = dq_oe;
        end
    end

    // Scoreboard: stimulus pushes, monitor pops on every ack/err
    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          lat;
        int          stamp;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (rst_n && (ack || err)) begin
            chk("ack_err_excl", {31'b0, ack & err}, 32'h0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b want no response", ack, err);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_kind", {31'b0, err}, {31'b0, e.is_err});
                chk("latency", cyc_cnt - e.stamp + 1, e.lat);
                if (e.chk_dat) chk("rdata", rdata, e.dat);
            end
        end
    end

    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit is_err, input logic [31:0] exp_dat, input int lat);
        bit got;
        @(negedge clk);
        wstb = 0; rstb = 0; ce_lo = 0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        sbq.push_back('{is_err, (!w && !is_err), exp_dat, lat, cyc_cnt + 1});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack || err) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: got no ack/err within 40 cycles want a response");
            sbq.delete();
        end
    endtask

    function automatic logic [31:0] pins();
        return {24'b0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, ack, err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; sel = 0; dq_in = 0;
        repeat (4) begin
            @(negedge clk);
            cyc = 1'($urandom); stb = 1'($urandom); we = 1'($urandom);
            addr = $urandom; wdata = $urandom; sel = 4'($urandom);
        end
        chk("rst_pins", pins(), 32'h0000_00F8);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", {14'b0, sram_addr}, 32'h0);
        chk("rst_dqout", {16'b0, dq_out}, 32'h0);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full write, two halves
        wb_xfer(1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0, 9);
        chk("fw_mem20", {16'b0, rd(32'h20)}, 32'h0000_BEEF);
        chk("fw_mem21", {16'b0, rd(32'h21)}, 32'h0000_DEAD);
        chk("fw_wstb", wstb, 4);

        // Readbacks
        wb_xfer(0, 32'h10, 32'h0, 4'b1111, 0, 32'hDEADBEEF, 9);
        chk("rd_rstb", rstb, 4);
        wb_xfer(0, 32'h10, 32'h0, 4'b0011, 0, 32'h0000BEEF, 5);
        chk("rdlo_rstb", rstb, 2);

        // Single byte write on the upper halfword
        wb_xfer(1, 32'h10, 32'h00AA0000, 4'b0100, 0, 32'h0, 5);
        chk("bw_wstb", wstb, 2);
        chk("bw_addr", {14'b0, last_addr}, 32'h21);
        chk("bw_lanes", {30'b0, last_lanes}, 32'h2);
        chk("bw_dq", {16'b0, last_dq}, 32'h00AA);
        chk("bw_dqoe", {31'b0, last_dqoe}, 32'h1);
        chk("bw_mem21", {16'b0, rd(32'h21)}, 32'h0000_DEAA);
        wb_xfer(0, 32'h10, 32'h0, 4'b1111, 0, 32'hDEAABEEF, 9);
        wb_xfer(0, 32'h10, 32'h0, 4'b1000, 0, 32'hDE000000, 5);

        // Out of range and empty select
        wb_xfer(0, 32'h0002_0000, 32'h0, 4'b1111, 1, 32'h0, 1);
        chk("err_ce_lo", ce_lo, 0);
        wb_xfer(0, 32'h10, 32'h0, 4'b0000, 0, 32'h0, 1);
        chk("sel0_ce_lo", ce_lo, 0);

        // Abort: drop cyc during the first strobe
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; addr = 32'h40; wdata = 32'h12345678; sel = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_we", {31'b0, we_n}, 32'h0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        chk("abort_pins", pins(), 32'h0000_00F8);
        repeat (12) @(negedge clk);

        // Async reset in the middle of a read strobe
        cyc = 1; stb = 1; we = 0; addr = 32'h10; sel = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pre_oe", {31'b0, oe_n}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pins", pins(), 32'h0000_00F8);
        chk("midrst_rdata", rdata, 32'h0);
        cyc = 0; stb = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb_xfer(0, 32'h10, 32'h0, 4'b1111, 0, 32'hDEAABEEF, 9);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wbsram16.md
Name: wbsram16

Overview:
- Wishbone classic (B3) slave that bridges one crossbar slave port to an external 16-bit asynchronous SRAM.
- Each 32-bit Wishbone word is served as up to two 16-bit SRAM accesses, low half first, with programmable strobe width and byte-lane masking.
- Sits on the responder side of the crossbar, attached to one o_s*/i_s* port slice.

Parameters:
AW, 32, Wishbone address width; i_wb_addr is a 32-bit word address.
DW, 32, Wishbone data width; fixed at 32.
SW, 4, byte selects, DW/8.
MUXWIDTH, 3, top address bits used for slave select; ignored by this block.
SRAM_AW, 18, SRAM halfword address width.
WAIT_CYCLES, 2, cycles oe_n/we_n are held low per halfword; range 1..15.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  AW  word address
i_wb_data  in  DW  write data
i_wb_sel  in  SW  byte selects
o_wb_ack  out  1  acknowledge, single-cycle pulse
o_wb_data  out  DW  read data, registered
o_wb_err  out  1  error, single-cycle pulse
o_sram_addr  out  SRAM_AW  halfword address
o_sram_dq_out  out  16  write data to pad
o_sram_dq_oe  out  1  pad output enable, active high
i_sram_dq_in  in  16  read data from pad
o_sram_ce_n  out  1  chip enable
o_sram_oe_n  out  1  output enable
o_sram_we_n  out  1  write enable
o_sram_lb_n  out  1  lower byte enable
o_sram_ub_n  out  1  upper byte enable

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - ce_n, oe_n, we_n, lb_n, ub_n = 1; dq_oe = 0; sram_addr = 0; dq_out = 0.
  - ack = 0; err = 0; o_wb_data = 0.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- Request acceptance: in IDLE, cyc & stb & !ack & !err, sampled at edge 0.
  - Latch we, data, sel and word address. Compute H = number of halves whose sel pair is nonzero (0..2).
- Range check: if i_wb_addr[AW-MUXWIDTH-1:SRAM_AW-1] != 0:
  - err = 1 in cycle 1, no ack, no SRAM activity, back to IDLE.
- H = 0: ack in cycle 1, no SRAM activity, o_wb_data = 0.
- Per selected half (h=0 uses sel[1:0] and data[15:0]; h=1 uses sel[3:2] and data[31:16]):
  - sram_addr = {word_addr[SRAM_AW-2:0], h}.
  - SETUP, 1 cycle: ce_n = 0; lb_n = !sel[2h]; ub_n = !sel[2h+1]; oe_n = we_n = 1. For writes, dq_oe = 1 and dq_out = half data.
  - STROBE, WAIT_CYCLES cycles: oe_n = 0 (read) or we_n = 0 (write). Read data is captured from i_sram_dq_in at the last STROBE edge.
  - HOLD, 1 cycle: oe_n = we_n = 1; ce_n, addr, lanes and dq held.
  - A half with a zero sel pair is skipped entirely.
- DONE: ack = 1 for exactly one cycle.
  - On reads, o_wb_data holds the captured halves; skipped halves and unselected bytes read 0.
  - Next state is IDLE; ce_n = 1; dq_oe = 0.
- Latency: ack is high in cycle (WAIT_CYCLES+2)*H + 1 after the accepting edge. With default WAIT_CYCLES=2: 9 for H=2, 5 for H=1.
- Back-to-back: the earliest next acceptance is the edge after DONE. The ack gate prevents a stale stb from re-triggering.
- Abort: cyc low in any non-IDLE state.
  - Next edge: state IDLE, all strobes high, dq_oe = 0, no ack/err.
  - A partial write may have completed; this is acceptable.
- stb low while cyc stays high mid-transfer: ignored, the transfer completes.
- o_wb_data is stable outside DONE (retains its last value).
- ack and err are never high simultaneously.
- Reset mid-operation: all outputs immediately take their reset values.

Test Plan:
- Reset check: hold i_reset_n = 0 with random inputs -> ce/oe/we/lb/ub_n = 1, dq_oe = 0, ack = err = 0, o_wb_data = 0.
- Full write: addr 0x10, sel 4'b1111, data 0xDEADBEEF, WAIT_CYCLES 2 -> SRAM model has halfword 0x20 = 0xBEEF and 0x21 = 0xDEAD; we_n low 2 cycles per half; ack in cycle 9 only.
- Readback: read addr 0x10, sel 4'b1111 -> o_wb_data = 0xDEADBEEF with ack in cycle 9. Then read with sel 4'b0011 -> 0x0000BEEF, single half access, ack in cycle 5.
- Byte write: sel 4'b0100, data 0x00AA0000 -> one access at halfword 0x21 with lb_n = 0, ub_n = 1, dq_out = 0x00AA; ack in cycle 5.
- Errors and empty selects: addr with bit 17 set -> err in cycle 1, ce_n stays 1. Separately, sel 4'b0000 -> ack in cycle 1, no SRAM access.
- Abort and reset: drop cyc in cycle 3 of a write -> strobes high on the next edge, no ack. Assert i_reset_n low during STROBE -> outputs reset asynchronously, and the next request works normally.
